// File: rtl/gate_hero_pkg.sv
// Shared types and constants for the note lane engine: colours, judgement codes,
// scoring weights and scanner states.
package gate_hero_pkg;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] BLUE  = 3'b001;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] CYAN  = 3'b011;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] WHITE = 3'b111;

  localparam int PERFECT_PTS = 2;
  localparam int GOOD_PTS    = 1;

  typedef enum logic [2:0] {
    J_NONE,
    J_STRAY,
    J_GOOD,
    J_PERFECT,
    J_MISS
  } judge_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_GAP
  } scan_state_t;

endpackage

// File: rtl/lane_judge.sv
// One lane: scrolling track register, key edge detection and press/miss judgement
// against the hit and near rows, plus the visible window for the scanner.
module lane_judge
  import gate_hero_pkg::*;
#(
  parameter int SONG_LEN = 105,
  parameter int WINDOW   = 15
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                load,
  input  logic                run,
  input  logic                tick,
  input  logic [SONG_LEN-1:0] song_lane,
  input  logic                key,
  output judge_t              judge,
  output logic                miss,
  output logic [WINDOW-1:0]   window,
  output logic                hit_bit,
  output logic                empty
);

  logic [SONG_LEN-1:0] track_reg;
  logic [SONG_LEN-1:0] track_next;
  logic [SONG_LEN-1:0] cleared;
  logic                key_s_reg;
  logic                key_q_reg;
  logic                active;
  logic                press;

  // key_s_reg samples the PS/2 level; the edge is taken between the two stages.
  assign active = run & ~load;
  assign press  = active & key_s_reg & ~key_q_reg;

  always_comb begin
    cleared = track_reg;
    judge   = J_NONE;
    if (press) begin
      if (track_reg[SONG_LEN-1]) begin
        judge                = J_PERFECT;
        cleared[SONG_LEN-1]  = 1'b0;
      end else if (track_reg[SONG_LEN-2]) begin
        judge                = J_GOOD;
        cleared[SONG_LEN-2]  = 1'b0;
      end else begin
        judge = J_STRAY;
      end
    end
    // A note still sitting in the hit row when the track scrolls is lost.
    miss       = active & tick & cleared[SONG_LEN-1];
    track_next = (active & tick) ? {cleared[SONG_LEN-2:0], 1'b0} : cleared;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      track_reg <= '0;
      key_s_reg <= 1'b0;
      key_q_reg <= 1'b0;
    end else if (load) begin
      track_reg <= song_lane;
      key_s_reg <= 1'b0;
      key_q_reg <= 1'b0;
    end else begin
      track_reg <= track_next;
      key_s_reg <= key;
      key_q_reg <= key_s_reg;
    end
  end

  assign window  = track_reg[SONG_LEN-1 -: WINDOW];
  assign hit_bit = track_reg[SONG_LEN-1];
  assign empty   = ~|track_reg;

endmodule

// File: rtl/note_lane_engine.sv
// Multi-lane rhythm game datapath: per-lane judges, a raster scanner that emits
// one plot per window cell, and saturating score/combo/max-combo accumulators.
module note_lane_engine
  import gate_hero_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int SONG_LEN = 105,
  parameter int WINDOW   = 15,
  parameter int FIRST_X  = 48,
  parameter int X_OFFSET = 16,
  parameter int FIRST_Y  = 1,
  parameter int Y_OFFSET = 8,
  parameter int SCORE_W  = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      load,
  input  logic                      run,
  input  logic                      tick,
  input  logic [LANES*SONG_LEN-1:0] song,
  input  logic [LANES-1:0]          keys,
  output logic [7:0]                x_out,
  output logic [6:0]                y_out,
  output logic [2:0]                c_out,
  output logic                      plot,
  output logic [SCORE_W-1:0]        score,
  output logic [SCORE_W-1:0]        combo,
  output logic [SCORE_W-1:0]        max_combo,
  output logic [LANES-1:0]          hit_row,
  output logic                      done
);

  localparam int CELLS  = LANES * WINDOW;
  localparam int LANE_W = $clog2(LANES);
  localparam int ROW_W  = $clog2(WINDOW);
  localparam int CELL_W = $clog2(CELLS);
  localparam int ACC_W  = SCORE_W + 5;
  localparam logic [ACC_W-1:0] SAT = ACC_W'({SCORE_W{1'b1}});

  judge_t               judge [LANES];
  logic [LANES-1:0]     miss;
  logic [LANES-1:0]     empty;
  logic [CELLS-1:0]     cells;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    lane_judge #(
      .SONG_LEN(SONG_LEN),
      .WINDOW  (WINDOW)
    ) u_lane (
      .clk      (clk),
      .resetn   (resetn),
      .load     (load),
      .run      (run),
      .tick     (tick),
      .song_lane(song[gi*SONG_LEN +: SONG_LEN]),
      .key      (keys[gi]),
      .judge    (judge[gi]),
      .miss     (miss[gi]),
      .window   (cells[gi*WINDOW +: WINDOW]),
      .hit_bit  (hit_row[gi]),
      .empty    (empty[gi])
    );
  end

  assign done = run & (&empty);

  scan_state_t       state_reg, state_next;
  logic [LANE_W-1:0] lane_reg, lane_next;
  logic [ROW_W-1:0]  row_reg, row_next;
  logic              plot_next;
  logic [7:0]        x_next;
  logic [6:0]        y_next;
  logic [2:0]        c_next;
  logic              last_row, last_lane;
  logic [CELL_W-1:0] cell_idx;

  assign last_row  = (row_reg == ROW_W'(WINDOW - 1));
  assign last_lane = (lane_reg == LANE_W'(LANES - 1));
  assign cell_idx  = CELL_W'(int'(lane_reg) * WINDOW + int'(row_reg));

  always_comb begin
    state_next = state_reg;
    lane_next  = lane_reg;
    row_next   = row_reg;
    plot_next  = 1'b0;
    x_next     = x_out;
    y_next     = y_out;
    c_next     = c_out;
    case (state_reg)
      S_IDLE: begin
        if (run) begin
          state_next = S_SCAN;
          lane_next  = '0;
          row_next   = '0;
        end
      end
      S_SCAN: begin
        if (!run) begin
          state_next = S_IDLE;
        end else begin
          plot_next = 1'b1;
          x_next    = 8'(FIRST_X + int'(lane_reg) * X_OFFSET);
          y_next    = 7'(FIRST_Y + int'(row_reg) * Y_OFFSET);
          if (!cells[cell_idx])                      c_next = BLACK;
          else if (lane_reg == '0 || last_lane)      c_next = GREEN;
          else                                       c_next = BLUE;
          if (last_row) begin
            row_next = '0;
            if (last_lane) begin
              lane_next  = '0;
              state_next = S_GAP;
            end else begin
              lane_next = lane_reg + LANE_W'(1);
            end
          end else begin
            row_next = row_reg + ROW_W'(1);
          end
        end
      end
      S_GAP:   state_next = run ? S_SCAN : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  logic [ACC_W-1:0]   pts_sum, hit_sum, score_sum, combo_sum;
  logic               bad;
  logic [SCORE_W-1:0] score_next, combo_next, max_next;

  always_comb begin
    pts_sum = '0;
    hit_sum = '0;
    bad     = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      case (judge[l])
        J_PERFECT: begin
          pts_sum = pts_sum + ACC_W'(PERFECT_PTS);
          hit_sum = hit_sum + ACC_W'(1);
        end
        J_GOOD: begin
          pts_sum = pts_sum + ACC_W'(GOOD_PTS);
          hit_sum = hit_sum + ACC_W'(1);
        end
        J_STRAY: bad = 1'b1;
        default: ;
      endcase
      if (miss[l]) bad = 1'b1;
    end
    score_sum  = ACC_W'(score) + pts_sum;
    combo_sum  = ACC_W'(combo) + hit_sum;
    score_next = (score_sum > SAT) ? SAT[SCORE_W-1:0] : score_sum[SCORE_W-1:0];
    if (bad)                  combo_next = '0;
    else if (combo_sum > SAT) combo_next = SAT[SCORE_W-1:0];
    else                      combo_next = combo_sum[SCORE_W-1:0];
    max_next = (combo_next > max_combo) ? combo_next : max_combo;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= S_IDLE;
      lane_reg  <= '0;
      row_reg   <= '0;
      plot      <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      c_out     <= '0;
      score     <= '0;
      combo     <= '0;
      max_combo <= '0;
    end else if (load) begin
      state_reg <= S_IDLE;
      lane_reg  <= '0;
      row_reg   <= '0;
      plot      <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      c_out     <= '0;
      score     <= '0;
      combo     <= '0;
      max_combo <= '0;
    end else begin
      state_reg <= state_next;
      lane_reg  <= lane_next;
      row_reg   <= row_next;
      plot      <= plot_next;
      x_out     <= x_next;
      y_out     <= y_next;
      c_out     <= c_next;
      score     <= score_next;
      combo     <= combo_next;
      max_combo <= max_next;
    end
  end

endmodule

// File: tb/tb_note_lane_engine.sv
// Self-checking bench for note_lane_engine: directed scenarios plus randomized
// play, all compared every cycle against a behavioural model of the game rules.
module tb_note_lane_engine;

  localparam int LANES    = 4;
  localparam int SONG_LEN = 105;
  localparam int WINDOW   = 15;
  localparam int SW       = 4;
  localparam int SAT      = (1 << SW) - 1;
  localparam int CELLS    = LANES * WINDOW;

  logic                      clk = 1'b0;
  logic                      resetn = 1'b0;
  logic                      load = 1'b0;
  logic                      run = 1'b0;
  logic                      tick = 1'b0;
  logic [LANES*SONG_LEN-1:0] song = '0;
  logic [LANES-1:0]          keys = '0;
  logic [7:0]                x_out;
  logic [6:0]                y_out;
  logic [2:0]                c_out;
  logic                      plot;
  logic [SW-1:0]             score, combo, max_combo;
  logic [LANES-1:0]          hit_row;
  logic                      done;

  note_lane_engine #(
    .LANES(LANES), .SONG_LEN(SONG_LEN), .WINDOW(WINDOW),
    .FIRST_X(48), .X_OFFSET(16), .FIRST_Y(1), .Y_OFFSET(8), .SCORE_W(SW)
  ) dut (
    .clk(clk), .resetn(resetn), .load(load), .run(run), .tick(tick),
    .song(song), .keys(keys), .x_out(x_out), .y_out(y_out), .c_out(c_out),
    .plot(plot), .score(score), .combo(combo), .max_combo(max_combo),
    .hit_row(hit_row), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [SONG_LEN-1:0] m_trk [LANES];
  logic [LANES-1:0]    m_ks, m_kq;
  int m_score, m_combo, m_max, m_pos, m_plot, m_x, m_y, m_c;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < LANES; l++) m_trk[l] = '0;
    m_ks = '0; m_kq = '0;
    m_score = 0; m_combo = 0; m_max = 0;
    m_pos = -1; m_plot = 0; m_x = 0; m_y = 0; m_c = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int pts, hits, lane, row;
    bit bad;
    if (load) begin
      model_reset();
      for (int l = 0; l < LANES; l++) m_trk[l] = song[l*SONG_LEN +: SONG_LEN];
      return;
    end
    // Scanner: m_pos is the cell index 0..CELLS-1, CELLS = gap, -1 = idle.
    if (m_pos < 0) begin
      m_plot = 0;
      if (run) m_pos = 0;
    end else if (!run) begin
      m_plot = 0; m_pos = -1;
    end else if (m_pos < CELLS) begin
      lane = m_pos / WINDOW;
      row  = m_pos % WINDOW;
      m_plot = 1;
      m_x = (48 + lane * 16) % 256;
      m_y = (1 + row * 8) % 128;
      if (!m_trk[lane][SONG_LEN-WINDOW+row]) m_c = 0;
      else if (lane == 0 || lane == LANES-1) m_c = 2;
      else m_c = 1;
      m_pos++;
    end else begin
      m_plot = 0; m_pos = 0;
    end
    // Judging against the pre-shift window.
    pts = 0; hits = 0; bad = 0;
    for (int l = 0; l < LANES; l++) begin
      if (run && m_ks[l] && !m_kq[l]) begin
        if (m_trk[l][SONG_LEN-1]) begin
          pts += 2; hits++; m_trk[l][SONG_LEN-1] = 1'b0;
        end else if (m_trk[l][SONG_LEN-2]) begin
          pts += 1; hits++; m_trk[l][SONG_LEN-2] = 1'b0;
        end else bad = 1;
      end
      if (run && tick) begin
        if (m_trk[l][SONG_LEN-1]) bad = 1;
        m_trk[l] = m_trk[l] << 1;
      end
    end
    m_kq = m_ks;
    m_ks = keys;
    m_score = (m_score + pts > SAT) ? SAT : m_score + pts;
    if (bad) m_combo = 0;
    else m_combo = (m_combo + hits > SAT) ? SAT : m_combo + hits;
    if (m_combo > m_max) m_max = m_combo;
  endtask

  task automatic compare_all();
    logic [LANES-1:0] exp_hit;
    bit all_empty;
    all_empty = 1;
    for (int l = 0; l < LANES; l++) begin
      exp_hit[l] = m_trk[l][SONG_LEN-1];
      if (m_trk[l] != '0) all_empty = 0;
    end
    check("plot", int'(plot), m_plot);
    check("x", int'(x_out), m_x);
    check("y", int'(y_out), m_y);
    check("c", int'(c_out), m_c);
    check("score", int'(score), m_score);
    check("combo", int'(combo), m_combo);
    check("max_combo", int'(max_combo), m_max);
    check("hit_row", int'(hit_row), int'(exp_hit));
    check("done", int'(done), int'(run && all_empty));
  endtask

  task automatic step(input bit ld, input bit rn, input bit tk, input logic [LANES-1:0] k);
    @(negedge clk);
    load = ld; run = rn; tick = tk; keys = k;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    int n_plot, fx, fy, lx, ly;
    logic [LANES-1:0] k;
    bit rn, tk, ld;

    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_plot", int'(plot), 0);
    check("rst_score", int'(score), 0);
    check("rst_hit_row", int'(hit_row), 0);
    check("rst_done", int'(done), 0);
    @(negedge clk);
    resetn = 1'b1;

    // T1: scan pattern, then PERFECT on lane 0
    song = '0; song[104] = 1'b1;
    step(1, 0, 0, '0);
    n_plot = 0; fx = -1; fy = -1; lx = -1; ly = -1;
    for (int i = 0; i < CELLS + 1; i++) begin
      step(0, 1, 0, '0);
      if (plot) begin
        n_plot++;
        if (n_plot == 1) begin fx = x_out; fy = y_out; end
        lx = x_out; ly = y_out;
      end
    end
    check("scan_plots", n_plot, 60);
    check("scan_first_x", fx, 48);
    check("scan_first_y", fy, 1);
    check("scan_last_x", lx, 96);
    check("scan_last_y", ly, 113);
    step(0, 1, 0, '0);
    check("scan_gap_plot", int'(plot), 0);
    step(0, 1, 0, 4'b0001);
    check("t1_score_early", int'(score), 0);
    step(0, 1, 0, 4'b0001);
    check("t1_score", int'(score), 2);
    check("t1_combo", int'(combo), 1);
    check("t1_hit_row", int'(hit_row[0]), 0);
    for (int i = 0; i < CELLS + 2; i++) step(0, 1, 0, 4'b0001);
    $display("phase t1: score=%0d combo=%0d", score, combo);

    // T2: GOOD then STRAY on lane 1
    song = '0; song[SONG_LEN + 103] = 1'b1;
    step(1, 0, 0, '0);
    step(0, 1, 0, '0);
    repeat (2) step(0, 1, 0, 4'b0010);
    check("t2_good_score", int'(score), 1);
    check("t2_good_combo", int'(combo), 1);
    repeat (2) step(0, 1, 0, '0);
    repeat (2) step(0, 1, 0, 4'b0010);
    check("t2_stray_score", int'(score), 1);
    check("t2_stray_combo", int'(combo), 0);
    check("t2_stray_max", int'(max_combo), 1);
    $display("phase t2: score=%0d combo=%0d max=%0d", score, combo, max_combo);

    // T3: MISS on lane 2
    song = '0; song[2*SONG_LEN + 104] = 1'b1;
    step(1, 0, 0, '0);
    step(0, 1, 0, '0);
    check("t3_hit_before", int'(hit_row), 4);
    step(0, 1, 1, '0);
    check("t3_score", int'(score), 0);
    check("t3_combo", int'(combo), 0);
    check("t3_max", int'(max_combo), 0);
    check("t3_hit_after", int'(hit_row), 0);
    $display("phase t3: score=%0d combo=%0d", score, combo);

    // T4: all four lanes PERFECT together, then an empty tick
    song = '0;
    for (int l = 0; l < LANES; l++) song[l*SONG_LEN + 104] = 1'b1;
    step(1, 0, 0, '0);
    step(0, 1, 0, '0);
    repeat (2) step(0, 1, 0, 4'b1111);
    check("t4_score", int'(score), 8);
    check("t4_combo", int'(combo), 4);
    check("t4_max", int'(max_combo), 4);
    step(0, 1, 1, 4'b1111);
    check("t4_hold_score", int'(score), 8);
    check("t4_hold_combo", int'(combo), 4);
    $display("phase t4: score=%0d combo=%0d max=%0d", score, combo, max_combo);

    // T5: eight PERFECTs with a 4-bit score saturate at 15
    song = '0;
    for (int l = 0; l < LANES; l++) begin
      song[l*SONG_LEN + 104] = 1'b1;
      song[l*SONG_LEN + 103] = 1'b1;
    end
    step(1, 0, 0, '0);
    step(0, 1, 0, '0);
    repeat (2) step(0, 1, 0, 4'b1111);
    repeat (2) step(0, 1, 0, '0);
    step(0, 1, 1, '0);
    repeat (2) step(0, 1, 0, 4'b1111);
    check("t5_score_sat", int'(score), 15);
    check("t5_combo", int'(combo), 8);
    check("t5_max", int'(max_combo), 8);
    $display("phase t5: score=%0d combo=%0d", score, combo);

    // Asynchronous reset in the middle of a scan
    for (int b = 0; b < LANES*SONG_LEN; b++) song[b] = ($urandom_range(0, 3) == 0);
    step(1, 0, 0, '0);
    repeat (30) step(0, 1, 0, '0);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("arst_plot", int'(plot), 0);
    check("arst_x", int'(x_out), 0);
    check("arst_y", int'(y_out), 0);
    check("arst_c", int'(c_out), 0);
    check("arst_hit_row", int'(hit_row), 0);
    model_reset();
    run = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    $display("phase arst: plot=%0d x=%0d y=%0d", plot, x_out, y_out);

    // Randomized play
    k = '0;
    for (int seg = 0; seg < 5; seg++) begin
      for (int b = 0; b < LANES*SONG_LEN; b++) song[b] = ($urandom_range(0, 3) == 0);
      step(1, 0, 0, k);
      for (int i = 0; i < 600; i++) begin
        rn = ($urandom_range(0, 19) != 0);
        tk = ($urandom_range(0, 2) == 0);
        ld = ($urandom_range(0, 299) == 0);
        for (int l = 0; l < LANES; l++)
          if ($urandom_range(0, 2) == 0) k[l] = ~k[l];
        step(ld, rn, tk, k);
      end
      $display("phase random %0d: score=%0d combo=%0d max=%0d done=%0d",
               seg, score, combo, max_combo, done);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/note_lane_engine.md
# note_lane_engine

Parametrised successor to the fixed four-lane game datapath. It holds LANES song tracks, scrolls them on a tick, and scans the visible window into per-pixel plot writes for the VGA adapter. It also judges PS/2 key presses against the hit rows and keeps score, combo and max combo. The block sits between the control FSM (load/run), the rate dividers (tick) and the VGA adapter and hex decoders.

## Interface
Parameters:
- LANES, 4, number of lanes/keys (2..8)
- SONG_LEN, 105, bits per lane track
- WINDOW, 15, visible rows per lane (2..16)
- FIRST_X, 48, x of lane 0
- X_OFFSET, 16, x pitch between lanes
- FIRST_Y, 1, y of row 0
- Y_OFFSET, 8, y pitch between rows
- SCORE_W, 8, width of score/combo counters

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- resetn  in  1  asynchronous, active-low reset
- load  in  1  level; while high, latch song and clear all state
- run  in  1  level; enables scroll, scan and judging
- tick  in  1  one-cycle scroll pulse (from rate_divider, already in clk domain)
- song  in  LANES*SONG_LEN  lane L occupies bits [L*SONG_LEN +: SONG_LEN]
- keys  in  LANES  level per lane, 1 = pressed
- x_out  out  8  pixel x
- y_out  out  7  pixel y
- c_out  out  3  colour
- plot  out  1  write strobe to VGA adapter
- score  out  SCORE_W  total score
- combo  out  SCORE_W  current combo
- max_combo  out  SCORE_W  best combo since load
- hit_row  out  LANES  current hit-row bit per lane (LED drive)
- done  out  1  all tracks empty while run

## Operation
- Track L is a SONG_LEN shift register. On load it copies song. On tick with run and !load it shifts toward the MSB, with 0 entering the LSB.
- Window row w (0..WINDOW-1) = track bit SONG_LEN-WINDOW+w.
- Row WINDOW-1 is the hit row. Row WINDOW-2 is the near row.
- Scanner FSM:
  - States IDLE, SCAN, GAP.
  - IDLE→SCAN when run.
  - SCAN steps (lane, row) one cell per clk, row fastest, lane 0 first.
  - After cell (LANES-1, WINDOW-1) → GAP for one cycle, with plot=0 and no write at (0,0).
  - GAP→SCAN, or →IDLE if !run. SCAN→IDLE immediately when run drops.
- Pixel values:
  - x = FIRST_X + lane*X_OFFSET, y = FIRST_Y + row*Y_OFFSET. Computed at full width, then truncated to 8/7 bits.
  - c = BLACK (000) if the cell is empty.
  - Otherwise GREEN (010) for lanes 0 and LANES-1, BLUE (001) for inner lanes.
- Judging, per lane, only when run:
  - press = keys & ~keys_q, where keys_q is the registered keys.
  - If press and hit-row bit is 1: PERFECT, +2, bit cleared.
  - Else if press and near-row bit is 1: GOOD, +1, bit cleared.
  - Else if press: STRAY.
  - On tick, a hit-row bit still 1 as it shifts out is a MISS.
- Accumulators, evaluated per cycle across all lanes:
  - score += sum of weights, saturating at 2^SCORE_W-1.
  - If any MISS or STRAY that cycle: combo ← 0.
  - Otherwise combo += count of PERFECT+GOOD, saturating.
  - max_combo ← max(max_combo, next combo).
- Press and tick in the same cycle: judge against the pre-shift window, then shift the post-clear contents.
- done = run & (all tracks == 0).

## Timing
- Reset (resetn low, async): tracks 0, keys_q 0, FSM IDLE, all outputs 0.
- load is synchronous and overrides run and tick. It does the same clear as reset but fills the tracks from song.
- x_out/y_out/c_out/plot are registered, one cycle after the cell counter. The first plot is 2 cycles after run rises.
- Full scan period = LANES*WINDOW+1 clks (61 at defaults).
- Score, combo and max_combo update on the clk edge after the press edge is detected. A press is visible 2 clks after keys rises.
- A key held across ticks counts once. keys_q follows keys even when run is low, so no phantom edge occurs at run rise.
- Reset mid-scan returns to IDLE with plot=0 on the same edge.

## Structure
- Package gate_hero_pkg:
  - colour localparams (BLACK, GREEN, BLUE, ...)
  - judgement enum {J_NONE, J_STRAY, J_GOOD, J_PERFECT, J_MISS}
  - weights PERFECT_PTS=2, GOOD_PTS=1
- Sub-module lane_judge (instantiated LANES times): track shift register, keys_q edge detect, judgement output, window bus.
- Top: scanner FSM, pixel register, score/combo/max accumulators.

## Test plan
- Defaults, track 0 bit 104 = 1, load, run, press keys[0] → score 2, combo 1, track bit cleared, next scan draws that cell BLACK.
- Track 1 bit 103 = 1, press keys[1] with no tick → GOOD: score 1, combo 1; same press again → STRAY, combo 0, score 1.
- Track 2 bit 104 = 1, no press, one tick → MISS: combo 0, max_combo unchanged; score 0.
- Press all 4 lanes in one cycle with all hit rows set → score 8, combo 4, max_combo 4; then one tick with no press and all rows empty → counters hold.
- Scan check: run for 61 clks → exactly 60 plot pulses, (x,y) sequence (48,1),(48,9)…(96,113), then one cycle plot=0; resetn low mid-scan → plot 0, x/y/c 0 asynchronously.
- Saturation: SCORE_W=4, 8 PERFECTs → score 15, not wrapping; combo saturates at 15.
